// File: rtl/cray_bxfer_pkg.sv
// Shared types and constants for the B-register block-transfer sequencer (Cray 034/035).
package cray_bxfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_RUN,
    ST_FETCH,
    ST_CAPT,
    ST_REQ,
    DONE
  } bxfer_state_e;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  localparam int BXFER_MAX_COUNT = 64;
  localparam int BXFER_CNT_W     = 7;

endpackage

// File: rtl/bxfer_cnt.sv
// 7-bit clearable up-counter with a terminal compare against the latched word count.
module bxfer_cnt
  import cray_bxfer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_inc,
  input  logic [BXFER_CNT_W-1:0] i_n,
  output logic [BXFER_CNT_W-1:0] o_cnt,
  output logic                   o_term
);

  logic [BXFER_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first (no latch) and use "=";
  //       clocked blocks use "<=" only.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)      cnt_d = '0;
    else if (i_inc) cnt_d = cnt_q + BXFER_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign o_cnt  = cnt_q;
  assign o_term = (cnt_q == i_n);

endmodule

// File: rtl/b_block_xfer.sv
// B-register block-transfer sequencer (034 memory->B, 035 B->memory).
// Optional abort input is built in when CRAY_BXFER_ABORT_EN is defined.
module b_block_xfer
  import cray_bxfer_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int LOGDEPTH = 6,
  parameter int AWIDTH   = 24,
  parameter int MWIDTH   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_dir,
  input  logic [LOGDEPTH-1:0] i_jk,
  input  logic [AWIDTH-1:0]   i_ak,
  input  logic [AWIDTH-1:0]   i_a0,
`ifdef CRAY_BXFER_ABORT_EN
  input  logic                i_abort,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mem_req,
  output logic                o_mem_wr,
  output logic [AWIDTH-1:0]   o_mem_addr,
  output logic [MWIDTH-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic                i_mem_rvalid,
  input  logic [MWIDTH-1:0]   i_mem_rdata,
  output logic                o_b_wr_en,
  output logic [LOGDEPTH-1:0] o_b_wr_addr,
  output logic [WIDTH-1:0]    o_b_wr_data,
  output logic [LOGDEPTH-1:0] o_b_rd_addr,
  input  logic [WIDTH-1:0]    i_b_rd_data
);

  bxfer_state_e           state_q, state_d;
  logic                   dir_q, dir_d;
  logic [BXFER_CNT_W-1:0] n_q, n_d;
  logic [LOGDEPTH-1:0]    jk_q, jk_d;
  logic [AWIDTH-1:0]      a0_q, a0_d;
  logic [LOGDEPTH-1:0]    b_rd_addr_q, b_rd_addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic                   b_wr_en_q, b_wr_en_d;
  logic [LOGDEPTH-1:0]    b_wr_addr_q, b_wr_addr_d;
  logic [WIDTH-1:0]       b_wr_data_q, b_wr_data_d;

  logic                   cnt_clr, req, ret_inc, abort_w;
  logic [BXFER_CNT_W-1:0] iss_cnt, ret_cnt;
  logic                   iss_term, ret_term, iss_last;

  // Only the low WIDTH bits of a memory word reach the B file.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^i_mem_rdata[MWIDTH-1:WIDTH];

`ifdef CRAY_BXFER_ABORT_EN
  // Abort is sticky for the rest of the transfer so a one-cycle pulse is enough.
  logic abort_q, abort_d;
  always_comb begin
    abort_d = abort_q | i_abort;
    if (state_q == IDLE) abort_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) abort_q <= 1'b0;
    else      abort_q <= abort_d;
  end
  assign abort_w = abort_q | i_abort;
`else
  assign abort_w = 1'b0;
`endif

  bxfer_cnt u_iss_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (req & i_mem_ack),
    .i_n    (n_q),
    .o_cnt  (iss_cnt),
    .o_term (iss_term)
  );

  bxfer_cnt u_ret_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (cnt_clr),
    .i_inc  (ret_inc),
    .i_n    (n_q),
    .o_cnt  (ret_cnt),
    .o_term (ret_term)
  );

  assign iss_last = ((iss_cnt + BXFER_CNT_W'(1)) == n_q);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    n_d         = n_q;
    jk_d        = jk_q;
    a0_d        = a0_q;
    b_rd_addr_d = b_rd_addr_q;
    wdata_d     = wdata_q;
    b_wr_en_d   = 1'b0;
    b_wr_addr_d = b_wr_addr_q;
    b_wr_data_d = b_wr_data_q;
    cnt_clr     = 1'b0;
    req         = 1'b0;
    ret_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          dir_d       = i_dir;
          n_d         = (i_ak > AWIDTH'(BXFER_MAX_COUNT)) ? BXFER_CNT_W'(BXFER_MAX_COUNT)
                                                          : BXFER_CNT_W'(i_ak);
          jk_d        = i_jk;
          a0_d        = i_a0;
          b_rd_addr_d = i_jk;
          cnt_clr     = 1'b1;
          state_d     = (i_dir == DIR_STORE) ? ST_FETCH : LD_RUN;
        end
      end
      LD_RUN: begin
        req = !iss_term && !abort_w;
        if (i_mem_rvalid && !ret_term) begin
          ret_inc     = 1'b1;
          b_wr_en_d   = 1'b1;
          b_wr_addr_d = jk_q + LOGDEPTH'(ret_cnt);
          b_wr_data_d = i_mem_rdata[WIDTH-1:0];
        end
        // An aborted load still drains every request already accepted by memory.
        if (ret_term || (abort_w && (ret_cnt == iss_cnt))) state_d = DONE;
      end
      ST_FETCH: state_d = (iss_term || abort_w) ? DONE : ST_CAPT;
      ST_CAPT: begin
        wdata_d = i_b_rd_data;
        state_d = abort_w ? DONE : ST_REQ;
      end
      ST_REQ: begin
        req = 1'b1;
        if (i_mem_ack) begin
          b_rd_addr_d = b_rd_addr_q + LOGDEPTH'(1);
          state_d     = (iss_last || abort_w) ? DONE : ST_FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dir_q       <= DIR_LOAD;
      n_q         <= '0;
      jk_q        <= '0;
      a0_q        <= '0;
      b_rd_addr_q <= '0;
      wdata_q     <= '0;
      b_wr_en_q   <= 1'b0;
      b_wr_addr_q <= '0;
      b_wr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      n_q         <= n_d;
      jk_q        <= jk_d;
      a0_q        <= a0_d;
      b_rd_addr_q <= b_rd_addr_d;
      wdata_q     <= wdata_d;
      b_wr_en_q   <= b_wr_en_d;
      b_wr_addr_q <= b_wr_addr_d;
      b_wr_data_q <= b_wr_data_d;
    end
  end

  assign o_busy      = (state_q != IDLE) && (state_q != DONE);
  assign o_done      = (state_q == DONE);
  assign o_mem_req   = req;
  assign o_mem_wr    = req && (dir_q == DIR_STORE);
  assign o_mem_addr  = req ? (a0_q + AWIDTH'(iss_cnt)) : '0;
  assign o_mem_wdata = MWIDTH'(wdata_q);
  assign o_b_wr_en   = b_wr_en_q;
  assign o_b_wr_addr = b_wr_addr_q;
  assign o_b_wr_data = b_wr_data_q;
  assign o_b_rd_addr = b_rd_addr_q;

endmodule

// File: doc/b_block_xfer.md
# b_block_xfer

B-register block-transfer sequencer for Cray instructions 034 (memory→B) and 035 (B→memory). It sits directly upstream of the B register file: it drives the file's write port for loads and its jk read port for stores. It also drives a single-request memory port. The count is taken from Ak and the memory base from A0. B addresses start at jk and wrap modulo 64.

## Interface
Parameters:
- WIDTH, 24: B register width
- LOGDEPTH, 6: B register address width
- AWIDTH, 24: memory address width
- MWIDTH, 64: memory word width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_dir  in  1  0 = load (034), 1 = store (035)
- i_jk  in  LOGDEPTH  first B register
- i_ak  in  AWIDTH  word count
- i_a0  in  AWIDTH  memory base address
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_mem_req  out  1  memory request, held until acknowledged
- o_mem_wr  out  1  request is a write
- o_mem_addr  out  AWIDTH  request address
- o_mem_wdata  out  MWIDTH  write data, zero-extended from B
- i_mem_ack  in  1  request accepted this cycle
- i_mem_rvalid  in  1  read data valid; responses return in order, any latency
- i_mem_rdata  in  MWIDTH  read data
- o_b_wr_en, o_b_wr_addr, o_b_wr_data  out  1/LOGDEPTH/WIDTH  B write port
- o_b_rd_addr  out  LOGDEPTH  B read address (file has 1-cycle registered read)
- i_b_rd_data  in  WIDTH  B read data

## Operation
- Effective count N = min(i_ak, 64), latched at start. N = 0 skips all transfers: DONE is entered the next cycle.
- Word n uses memory address (a0 + n) mod 2^AWIDTH and B address (jk + n) mod 64.
- States:
  - IDLE
  - LD_RUN
  - ST_FETCH
  - ST_CAPT
  - ST_REQ
  - DONE
- Load (LD_RUN):
  - o_mem_req stays high while issued < N. The issue counter advances on each i_mem_ack.
  - Each i_mem_rvalid writes rdata[WIDTH-1:0] to B address jk + returned, then advances the return counter.
  - Exit to DONE when returned = N.
- Store:
  - ST_FETCH registers o_b_rd_addr.
  - ST_CAPT latches i_b_rd_data into o_mem_wdata.
  - ST_REQ holds req/wr until i_mem_ack, then goes to ST_FETCH (next word) or to DONE after the Nth ack.
- DONE lasts one cycle: o_done = 1, o_busy = 0, then IDLE.
- Boundary rules:
  - i_start while busy is ignored.
  - i_mem_rvalid in IDLE, or in any store state, is ignored.
  - Ack and rvalid in the same cycle are both honoured.
  - A write at jk + n wrapping past 63 goes to address 0.
  - Reset mid-operation forces IDLE and clears counters. Responses still in flight after reset are dropped.
- Reset values: all outputs 0.

## Timing
- Load:
  - i_start is sampled at edge 0. o_busy and o_mem_req are high from cycle 1.
  - Peak rate is one request per cycle.
  - o_b_wr_en is asserted in the cycle after the matching i_mem_rvalid (registered).
  - o_done is asserted in the cycle after the final B write.
- Store:
  - Minimum 3 cycles per word: FETCH, CAPT, REQ with ack in its first cycle.
  - o_done is asserted in the cycle after the final ack.
- o_busy is combinational from state (not IDLE, not DONE).

## Configuration
- CRAY_BXFER_ABORT_EN
- Defined:
  - Adds input i_abort.
  - In any active state, issuing of new requests stops. Loads wait for outstanding returns and still write them to B. Stores finish the request currently held in ST_REQ.
  - Then DONE, with o_done pulsed as normal.
- Undefined: the port is absent and transfers always run to N.

## Structure
- Package cray_bxfer_pkg holds:
  - the state enum
  - DIR_LOAD and DIR_STORE constants
  - BXFER_MAX_COUNT = 64
- Sub-module bxfer_cnt: a 7-bit clearable counter with a terminal-compare against N. It is instantiated as the issue counter and the return counter.

## Test plan
- Load, jk = 10, Ak = 3, A0 = 0x100, memory with 2-cycle latency returning 0xAAA+n → B10..B12 = 0xAAA..0xAAC; exactly one o_done.
- Load, jk = 62, Ak = 4 → B62, B63, B0, B1 written; memory addresses A0..A0+3.
- Store, jk = 5, Ak = 2, B5 = 0x123, B6 = 0x456, ack delayed 3 cycles → writes to A0 and A0+1 with wdata 0x123 and 0x456 zero-extended.
- Ak = 0 → no o_mem_req and no o_b_wr_en; o_done in cycle 2. Ak = 0x1000 → exactly 64 words transferred.
- Reset asserted mid-load with 2 responses outstanding → all outputs 0 at once; late rvalid produces no B write.
- With CRAY_BXFER_ABORT_EN: abort after 2 of 8 load acks → no further requests; both outstanding returns are written; o_done follows.
